huffman_ctrl: RTL and testbench

Top-level sequencer for the Huffman compression pipeline. Accepts one 1024-bit frame (256 BCD nibbles) per transaction and clears and runs the frequency counter. Latches the resulting 130-bit frequency/symbol table, then steps the sort, tree-build and encode stages in order through start/done handshakes. A per-stage watchdog aborts a hung stage and reports which stage failed.

---
 rtl/huffman_pkg.sv | 46 ++++
 rtl/stage_watchdog.sv | 36 +++
 rtl/huffman_ctrl.sv | 166 ++++++++++++++++
 tb/tb_huffman_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/huffman_pkg.sv
// rtl/huffman_pkg.sv - shared types and constants for the Huffman pipeline controller
package huffman_pkg;

    localparam int FRAME_W_DEF = 1024;
    localparam int FREQ_W      = 8;
    localparam int SYM_W       = 5;
    localparam int NUM_SYMS    = 10;
    localparam int TABLE_W_DEF = NUM_SYMS * (FREQ_W + SYM_W);
    localparam int WD_W        = 12;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_COUNT  = 3'd2,
        ST_SORT   = 3'd3,
        ST_BUILD  = 3'd4,
        ST_ENCODE = 3'd5,
        ST_FINISH = 3'd6,
        ST_ABORT  = 3'd7
    } state_t;

    localparam logic [1:0] STG_COUNT = 2'd0;
    localparam logic [1:0] STG_SORT  = 2'd1;
    localparam logic [1:0] STG_BUILD = 2'd2;
    localparam logic [1:0] STG_ENC   = 2'd3;

    function automatic logic [1:0] stage_code(input state_t st);
        case (st)
            ST_SORT:   stage_code = STG_SORT;
            ST_BUILD:  stage_code = STG_BUILD;
            ST_ENCODE: stage_code = STG_ENC;
            default:   stage_code = STG_COUNT;
        endcase
    endfunction

    function automatic state_t next_stage(input state_t st);
        case (st)
            ST_COUNT:  next_stage = ST_SORT;
            ST_SORT:   next_stage = ST_BUILD;
            ST_BUILD:  next_stage = ST_ENCODE;
            ST_ENCODE: next_stage = ST_FINISH;
            default:   next_stage = ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/stage_watchdog.sv
// rtl/stage_watchdog.sv - cycle watchdog for a single pipeline stage
module stage_watchdog
    import huffman_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            enable,
    input  logic [WD_W-1:0] timeout,
    output logic            expired
);

    logic [WD_W-1:0] count_q;
    logic [WD_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // The count includes the current cycle, so a stage gets exactly `timeout` cycles.
    assign expired = enable && ((count_q + 1'b1) == timeout);

endmodule

// File: rtl/huffman_ctrl.sv
// rtl/huffman_ctrl.sv - frame sequencer for the count/sort/build/encode Huffman pipeline
module huffman_ctrl
    import huffman_pkg::*;
#(
    parameter int TIMEOUT = 1023,
    parameter int FRAME_W = FRAME_W_DEF,
    parameter int TABLE_W = TABLE_W_DEF
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               FRAME_VALID,
    output logic               FRAME_READY,
    input  logic [FRAME_W-1:0] FRAME_IN,
    output logic               CNT_nRST,
    output logic               CNT_GO,
    output logic [FRAME_W-1:0] CHARACTER_OUT,
    input  logic               COUNT_OVER,
    input  logic [TABLE_W-1:0] FREQUENT_IN,
    output logic [TABLE_W-1:0] FREQ_OUT,
    output logic               SORT_START,
    output logic               BUILD_START,
    output logic               ENC_START,
    input  logic               SORT_DONE,
    input  logic               BUILD_DONE,
    input  logic               ENC_DONE,
    output logic               BUSY,
    output logic               DONE,
    output logic               ERROR,
    output logic [1:0]         ERR_STAGE,
    output logic [7:0]         FRAME_CNT
);

    state_t             state_q, state_d;
    logic               frame_ready_q, frame_ready_d;
    logic               cnt_nrst_q, cnt_nrst_d;
    logic               cnt_go_q, cnt_go_d;
    logic [FRAME_W-1:0] char_q, char_d;
    logic [TABLE_W-1:0] freq_q, freq_d;
    logic               sort_start_q, sort_start_d;
    logic               build_start_q, build_start_d;
    logic               enc_start_q, enc_start_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic [1:0]         err_stage_q, err_stage_d;
    logic [7:0]         frame_cnt_q, frame_cnt_d;
    logic               awaited;
    logic               in_stage;
    logic               wd_expired;

    assign in_stage = (state_q == ST_COUNT) || (state_q == ST_SORT) ||
                      (state_q == ST_BUILD) || (state_q == ST_ENCODE);

    stage_watchdog u_watchdog (
        .clk     (CLK),
        .rst     (RST),
        .clear   (state_d != state_q),
        .enable  (in_stage),
        .timeout (WD_W'(TIMEOUT)),
        .expired (wd_expired)
    );

    always_comb begin
        state_d     = state_q;
        char_d      = char_q;
        freq_d      = freq_q;
        error_d     = error_q;
        err_stage_d = err_stage_q;
        frame_cnt_d = frame_cnt_q;
        awaited     = 1'b0;

        // Only the done input of the stage currently running is looked at.
        case (state_q)
            ST_COUNT:  awaited = COUNT_OVER;
            ST_SORT:   awaited = SORT_DONE;
            ST_BUILD:  awaited = BUILD_DONE;
            ST_ENCODE: awaited = ENC_DONE;
            default:   awaited = 1'b0;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (FRAME_VALID && frame_ready_q) begin
                    state_d = ST_CLEAR;
                    char_d  = FRAME_IN;
                    error_d = 1'b0;
                end
            end
            ST_CLEAR: state_d = ST_COUNT;
            ST_COUNT, ST_SORT, ST_BUILD, ST_ENCODE: begin
                if (awaited) begin
                    state_d = next_stage(state_q);
                    if (state_q == ST_COUNT) begin
                        freq_d = FREQUENT_IN;
                    end
                    if (state_q == ST_ENCODE) begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end else if (wd_expired) begin
                    state_d     = ST_ABORT;
                    error_d     = 1'b1;
                    err_stage_d = stage_code(state_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        frame_ready_d = (state_d == ST_IDLE);
        busy_d        = (state_d != ST_IDLE);
        cnt_nrst_d    = !((state_d == ST_CLEAR) || (state_d == ST_ABORT));
        cnt_go_d      = (state_d == ST_COUNT);
        sort_start_d  = (state_d == ST_SORT) && (state_q != ST_SORT);
        build_start_d = (state_d == ST_BUILD) && (state_q != ST_BUILD);
        enc_start_d   = (state_d == ST_ENCODE) && (state_q != ST_ENCODE);
        done_d        = (state_d == ST_FINISH);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= ST_IDLE;
            frame_ready_q <= 1'b0;
            cnt_nrst_q    <= 1'b0;
            cnt_go_q      <= 1'b0;
            char_q        <= '0;
            freq_q        <= '0;
            sort_start_q  <= 1'b0;
            build_start_q <= 1'b0;
            enc_start_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            err_stage_q   <= 2'd0;
            frame_cnt_q   <= 8'd0;
        end else begin
            state_q       <= state_d;
            frame_ready_q <= frame_ready_d;
            cnt_nrst_q    <= cnt_nrst_d;
            cnt_go_q      <= cnt_go_d;
            char_q        <= char_d;
            freq_q        <= freq_d;
            sort_start_q  <= sort_start_d;
            build_start_q <= build_start_d;
            enc_start_q   <= enc_start_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
            err_stage_q   <= err_stage_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign FRAME_READY   = frame_ready_q;
    assign CNT_nRST      = cnt_nrst_q;
    assign CNT_GO        = cnt_go_q;
    assign CHARACTER_OUT = char_q;
    assign FREQ_OUT      = freq_q;
    assign SORT_START    = sort_start_q;
    assign BUILD_START   = build_start_q;
    assign ENC_START     = enc_start_q;
    assign BUSY          = busy_q;
    assign DONE          = done_q;
    assign ERROR         = error_q;
    assign ERR_STAGE     = err_stage_q;
    assign FRAME_CNT     = frame_cnt_q;

endmodule

// File: tb/tb_huffman_ctrl.sv
// tb/tb_huffman_ctrl.sv - directed self-checking bench for huffman_ctrl
module tb_huffman_ctrl;

    localparam int T  = 1023;
    localparam int FW = 1024;
    localparam int TW = 130;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          FRAME_VALID = 1'b0;
    logic          FRAME_READY;
    logic [FW-1:0] FRAME_IN = '0;
    logic          CNT_nRST;
    logic          CNT_GO;
    logic [FW-1:0] CHARACTER_OUT;
    logic          COUNT_OVER = 1'b0;
    logic [TW-1:0] FREQUENT_IN = '0;
    logic [TW-1:0] FREQ_OUT;
    logic          SORT_START, BUILD_START, ENC_START;
    logic          SORT_DONE = 1'b0, BUILD_DONE = 1'b0, ENC_DONE = 1'b0;
    logic          BUSY, DONE, ERROR;
    logic [1:0]    ERR_STAGE;
    logic [7:0]    FRAME_CNT;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int acc_cyc, go_cyc, sort_cyc, build_cyc, enc_cyc, done_cyc, err_cyc, rdy_cyc;
    int n_acc, n_sort, n_build, n_enc, n_done, rdy_busy_bad, order_bad;
    bit finished;
    logic acc_nrst, err_at_acc, go_after, abort_nrst, abort_go;
    logic [TW-1:0] exp_freq;

    huffman_ctrl #(.TIMEOUT(T), .FRAME_W(FW), .TABLE_W(TW)) dut (
        .CLK(CLK), .RST(RST), .FRAME_VALID(FRAME_VALID), .FRAME_READY(FRAME_READY),
        .FRAME_IN(FRAME_IN), .CNT_nRST(CNT_nRST), .CNT_GO(CNT_GO),
        .CHARACTER_OUT(CHARACTER_OUT), .COUNT_OVER(COUNT_OVER), .FREQUENT_IN(FREQUENT_IN),
        .FREQ_OUT(FREQ_OUT), .SORT_START(SORT_START), .BUILD_START(BUILD_START),
        .ENC_START(ENC_START), .SORT_DONE(SORT_DONE), .BUILD_DONE(BUILD_DONE),
        .ENC_DONE(ENC_DONE), .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR),
        .ERR_STAGE(ERR_STAGE), .FRAME_CNT(FRAME_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    // Runs one frame with counter/stage stubs; lat_* < 0 means the stage never finishes.
    task automatic run_frame(input logic [FW-1:0] frame, input logic [TW-1:0] tbl,
                             input int lat_c, input int lat_s, input int lat_b,
                             input int lat_e, input bit stray_enc, input bit keep_valid,
                             input int budget);
        int go_n, sc, bc, ec;
        bit sa, ba, ea, busy_prev, go_prev;
        acc_cyc = -1; go_cyc = -1; sort_cyc = -1; build_cyc = -1; enc_cyc = -1;
        done_cyc = -1; err_cyc = -1; rdy_cyc = -1;
        n_acc = 0; n_sort = 0; n_build = 0; n_enc = 0; n_done = 0;
        rdy_busy_bad = 0; order_bad = 0; finished = 0;
        go_n = 0; sc = 0; bc = 0; ec = 0; sa = 0; ba = 0; ea = 0;
        busy_prev = BUSY; go_prev = CNT_GO;
        FRAME_IN = frame; FRAME_VALID = 1'b1; FREQUENT_IN = tbl;
        for (int i = 0; i < budget && !finished; i++) begin
            tick();
            if (BUSY && !busy_prev) begin
                n_acc++; acc_cyc = cyc; acc_nrst = CNT_nRST; err_at_acc = ERROR;
                if (!keep_valid) FRAME_VALID = 1'b0;
            end
            if (acc_cyc >= 0 && cyc == acc_cyc + 1) go_after = CNT_GO;
            if (CNT_GO && !go_prev) go_cyc = cyc;
            if (go_prev && !CNT_GO) exp_freq = FREQUENT_IN;
            if (SORT_START) begin n_sort++; sort_cyc = cyc; sa = 1; sc = 0; end
            else if (sa) sc++;
            if (BUILD_START) begin n_build++; build_cyc = cyc; ba = 1; bc = 0; if (n_sort == 0) order_bad++; end
            else if (ba) bc++;
            if (ENC_START) begin n_enc++; enc_cyc = cyc; ea = 1; ec = 0; if (n_build == 0) order_bad++; end
            else if (ea) ec++;
            if (DONE) begin n_done++; done_cyc = cyc; end
            if (ERROR && err_cyc < 0) begin err_cyc = cyc; abort_nrst = CNT_nRST; abort_go = CNT_GO; end
            if (FRAME_READY && BUSY) rdy_busy_bad++;
            if (FRAME_READY && acc_cyc >= 0) begin rdy_cyc = cyc; finished = 1; end
            go_n = CNT_GO ? go_n + 1 : 0;
            busy_prev = BUSY; go_prev = CNT_GO;
            COUNT_OVER  = CNT_GO && (go_n >= lat_c);
            SORT_DONE   = sa && (sc == lat_s);
            BUILD_DONE  = ba && (bc == lat_b);
            ENC_DONE    = (ea && (ec == lat_e)) || (stray_enc && CNT_GO);
            FREQUENT_IN = tbl ^ TW'(cyc);
        end
        COUNT_OVER = 1'b0; SORT_DONE = 1'b0; BUILD_DONE = 1'b0; ENC_DONE = 1'b0;
        FRAME_VALID = keep_valid;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick(); tick();
        checks++; if (FRAME_READY !== 1'b0) begin errors++; $display("FAIL rst_ready got %0b want 0", FRAME_READY); end
        checks++; if (CNT_nRST !== 1'b0) begin errors++; $display("FAIL rst_nrst got %0b want 0", CNT_nRST); end
        checks++; if (CNT_GO !== 1'b0) begin errors++; $display("FAIL rst_go got %0b want 0", CNT_GO); end
        checks++; if ({SORT_START, BUILD_START, ENC_START} !== 3'b000) begin errors++; $display("FAIL rst_starts got %b want 000", {SORT_START, BUILD_START, ENC_START}); end
        checks++; if ({BUSY, DONE, ERROR} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b want 000", {BUSY, DONE, ERROR}); end
        checks++; if (ERR_STAGE !== 2'd0) begin errors++; $display("FAIL rst_err_stage got %0d want 0", ERR_STAGE); end
        checks++; if (FRAME_CNT !== 8'd0) begin errors++; $display("FAIL rst_frame_cnt got %0d want 0", FRAME_CNT); end
        checks++; if (CHARACTER_OUT !== '0) begin errors++; $display("FAIL rst_char got nonzero want 0"); end
        checks++; if (FREQ_OUT !== '0) begin errors++; $display("FAIL rst_freq got %h want 0", FREQ_OUT); end
        RST = 1'b0;
        tick();
        checks++; if (FRAME_READY !== 1'b1) begin errors++; $display("FAIL post_rst_ready got %0b want 1", FRAME_READY); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL post_rst_busy got %0b want 0", BUSY); end
    endtask

    task automatic test_nominal();
        logic [FW-1:0] fr;
        logic [TW-1:0] tb_tbl;
        fr = {32{32'h1357_9BDF}};
        tb_tbl = {2'b10, {4{32'hA5C3_0F96}}};
        run_frame(fr, tb_tbl, 259, 4, 4, 4, 1'b0, 1'b0, 3000);
        checks++; if (!finished) begin errors++; $display("FAIL nom_finish got timeout want ready"); end
        checks++; if ({n_sort, n_build, n_enc} !== {32'd1, 32'd1, 32'd1}) begin errors++; $display("FAIL nom_starts got %0d/%0d/%0d want 1/1/1", n_sort, n_build, n_enc); end
        checks++; if (order_bad !== 0) begin errors++; $display("FAIL nom_order got %0d want 0", order_bad); end
        checks++; if (acc_nrst !== 1'b0 || go_after !== 1'b1) begin errors++; $display("FAIL nom_clear got nrst=%0b go=%0b want 0/1", acc_nrst, go_after); end
        checks++; if (sort_cyc - go_cyc !== 259) begin errors++; $display("FAIL nom_count_len got %0d want 259", sort_cyc - go_cyc); end
        checks++; if (build_cyc - sort_cyc !== 5) begin errors++; $display("FAIL nom_sort_len got %0d want 5", build_cyc - sort_cyc); end
        checks++; if (enc_cyc - build_cyc !== 5) begin errors++; $display("FAIL nom_build_len got %0d want 5", enc_cyc - build_cyc); end
        checks++; if (done_cyc - enc_cyc !== 5) begin errors++; $display("FAIL nom_enc_len got %0d want 5", done_cyc - enc_cyc); end
        checks++; if (n_done !== 1) begin errors++; $display("FAIL nom_done got %0d want 1", n_done); end
        checks++; if (FRAME_CNT !== 8'd1) begin errors++; $display("FAIL nom_frame_cnt got %0d want 1", FRAME_CNT); end
        checks++; if (FREQ_OUT !== exp_freq) begin errors++; $display("FAIL nom_freq got %h want %h", FREQ_OUT, exp_freq); end
        checks++; if (CHARACTER_OUT !== fr) begin errors++; $display("FAIL nom_char got %h want %h", CHARACTER_OUT[31:0], fr[31:0]); end
        checks++; if (ERROR !== 1'b0) begin errors++; $display("FAIL nom_error got %0b want 0", ERROR); end
    endtask

    task automatic test_sort_hang();
        run_frame({32{32'h0246_8ACE}}, {TW{1'b1}}, 3, -1, 0, 0, 1'b0, 1'b0, 3000);
        checks++; if (!finished) begin errors++; $display("FAIL hang_finish got timeout want ready"); end
        checks++; if (err_cyc - sort_cyc !== T) begin errors++; $display("FAIL hang_len got %0d want %0d", err_cyc - sort_cyc, T); end
        checks++; if (ERROR !== 1'b1 || ERR_STAGE !== 2'd1) begin errors++; $display("FAIL hang_err got %0b/%0d want 1/1", ERROR, ERR_STAGE); end
        checks++; if (FRAME_CNT !== 8'd1) begin errors++; $display("FAIL hang_frame_cnt got %0d want 1", FRAME_CNT); end
        checks++; if (rdy_cyc !== err_cyc + 1) begin errors++; $display("FAIL hang_ready got %0d want %0d", rdy_cyc, err_cyc + 1); end
        checks++; if (abort_nrst !== 1'b0 || abort_go !== 1'b0) begin errors++; $display("FAIL hang_abort_cnt got %0b/%0b want 0/0", abort_nrst, abort_go); end
        checks++; if (n_build !== 0 || n_done !== 0) begin errors++; $display("FAIL hang_progress got %0d/%0d want 0/0", n_build, n_done); end
    endtask

    task automatic test_recovery();
        logic [FW-1:0] fr;
        fr = {16{64'hFEDC_BA98_7654_3210}};
        run_frame(fr, {TW{1'b0}}, 0, 0, 0, 0, 1'b0, 1'b0, 100);
        checks++; if (!finished) begin errors++; $display("FAIL rec_finish got timeout want ready"); end
        checks++; if (err_at_acc !== 1'b0) begin errors++; $display("FAIL rec_err_clear got %0b want 0", err_at_acc); end
        checks++; if (done_cyc - acc_cyc + 2 !== 7) begin errors++; $display("FAIL rec_latency got %0d want 7", done_cyc - acc_cyc + 2); end
        checks++; if (FRAME_CNT !== 8'd2 || n_done !== 1) begin errors++; $display("FAIL rec_done got cnt=%0d n=%0d want 2/1", FRAME_CNT, n_done); end
        checks++; if (ERR_STAGE !== 2'd1) begin errors++; $display("FAIL rec_err_stage_hold got %0d want 1", ERR_STAGE); end
        checks++; if (CHARACTER_OUT !== fr) begin errors++; $display("FAIL rec_char got %h want %h", CHARACTER_OUT[31:0], fr[31:0]); end
    endtask

    task automatic test_backpressure();
        bit drained;
        run_frame({32{32'h5555_AAAA}}, {TW{1'b0}}, 2, 1, 1, 1, 1'b0, 1'b1, 200);
        checks++; if (!finished) begin errors++; $display("FAIL bp_finish got timeout want ready"); end
        checks++; if (n_acc !== 1) begin errors++; $display("FAIL bp_accepts got %0d want 1", n_acc); end
        checks++; if (rdy_busy_bad !== 0) begin errors++; $display("FAIL bp_ready_busy got %0d want 0", rdy_busy_bad); end
        checks++; if (FRAME_CNT !== 8'd3) begin errors++; $display("FAIL bp_frame_cnt got %0d want 3", FRAME_CNT); end
        tick();
        checks++; if (BUSY !== 1'b1 || FRAME_READY !== 1'b0) begin errors++; $display("FAIL bp_reaccept got busy=%0b ready=%0b want 1/0", BUSY, FRAME_READY); end
        FRAME_VALID = 1'b0;
        COUNT_OVER = 1'b1; SORT_DONE = 1'b1; BUILD_DONE = 1'b1; ENC_DONE = 1'b1;
        drained = 0;
        for (int i = 0; i < 50 && !drained; i++) begin
            tick();
            if (FRAME_READY) drained = 1;
        end
        COUNT_OVER = 1'b0; SORT_DONE = 1'b0; BUILD_DONE = 1'b0; ENC_DONE = 1'b0;
        checks++; if (!drained || FRAME_CNT !== 8'd4) begin errors++; $display("FAIL bp_second got drained=%0b cnt=%0d want 1/4", drained, FRAME_CNT); end
    endtask

    task automatic test_stray_edge();
        run_frame({32{32'h0F0F_3C3C}}, {TW{1'b0}}, 6, 0, T - 1, 0, 1'b1, 1'b0, 3000);
        checks++; if (!finished) begin errors++; $display("FAIL edge_finish got timeout want ready"); end
        checks++; if (sort_cyc - go_cyc !== 6) begin errors++; $display("FAIL edge_stray_enc got count_len=%0d want 6", sort_cyc - go_cyc); end
        checks++; if (enc_cyc - build_cyc !== T) begin errors++; $display("FAIL edge_done_wins got %0d want %0d", enc_cyc - build_cyc, T); end
        checks++; if (err_cyc !== -1 || ERROR !== 1'b0) begin errors++; $display("FAIL edge_no_error got err_cyc=%0d err=%0b want -1/0", err_cyc, ERROR); end
        checks++; if (n_enc !== 1 || n_done !== 1 || FRAME_CNT !== 8'd5) begin errors++; $display("FAIL edge_done got enc=%0d done=%0d cnt=%0d want 1/1/5", n_enc, n_done, FRAME_CNT); end
    endtask

    task automatic test_reset_mid();
        bit seen_go, bad;
        FRAME_IN = {32{32'hDEAD_BEEF}};
        FRAME_VALID = 1'b1; COUNT_OVER = 1'b0;
        seen_go = 0;
        for (int i = 0; i < 10 && !seen_go; i++) begin
            tick();
            if (CNT_GO) seen_go = 1;
        end
        FRAME_VALID = 1'b0;
        checks++; if (!seen_go) begin errors++; $display("FAIL mid_go got 0 want 1"); end
        tick(); tick(); tick();
        RST = 1'b1;
        tick();
        checks++; if ({FRAME_READY, CNT_nRST, CNT_GO, BUSY, DONE, ERROR} !== 6'b0) begin errors++; $display("FAIL mid_rst_ctl got %b want 000000", {FRAME_READY, CNT_nRST, CNT_GO, BUSY, DONE, ERROR}); end
        checks++; if ({SORT_START, BUILD_START, ENC_START} !== 3'b000) begin errors++; $display("FAIL mid_rst_starts got %b want 000", {SORT_START, BUILD_START, ENC_START}); end
        checks++; if (FRAME_CNT !== 8'd0 || ERR_STAGE !== 2'd0) begin errors++; $display("FAIL mid_rst_cnt got %0d/%0d want 0/0", FRAME_CNT, ERR_STAGE); end
        checks++; if (CHARACTER_OUT !== '0 || FREQ_OUT !== '0) begin errors++; $display("FAIL mid_rst_data got nonzero want 0"); end
        RST = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (DONE || ERROR || BUSY) bad = 1;
        end
        checks++; if (bad || FRAME_READY !== 1'b1) begin errors++; $display("FAIL mid_after got bad=%0b ready=%0b want 0/1", bad, FRAME_READY); end
    endtask

    task automatic test_wrap();
        int n;
        logic [7:0] c255, c256;
        n = 0; c255 = 8'hxx; c256 = 8'hxx;
        FRAME_VALID = 1'b1;
        COUNT_OVER = 1'b1; SORT_DONE = 1'b1; BUILD_DONE = 1'b1; ENC_DONE = 1'b1;
        for (int i = 0; i < 2600 && n < 256; i++) begin
            tick();
            if (DONE) begin
                n++;
                if (n == 255) c255 = FRAME_CNT;
                if (n == 256) c256 = FRAME_CNT;
            end
        end
        FRAME_VALID = 1'b0;
        COUNT_OVER = 1'b0; SORT_DONE = 1'b0; BUILD_DONE = 1'b0; ENC_DONE = 1'b0;
        checks++; if (n !== 256) begin errors++; $display("FAIL wrap_frames got %0d want 256", n); end
        checks++; if (c255 !== 8'd255) begin errors++; $display("FAIL wrap_255 got %0d want 255", c255); end
        checks++; if (c256 !== 8'd0) begin errors++; $display("FAIL wrap_zero got %0d want 0", c256); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_sort_hang();
        test_recovery();
        test_backpressure();
        test_stray_edge();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1);
    end

endmodule
